im_fetch_ctrl: RTL

Fetch sequencer for the instruction memory. It owns the PC, drives the IM read address, and registers the returned word into the F/D pipeline register. It arbitrates between sequential fetch, branch/jump redirect, pipeline stall, exception entry and eret return, and it raises AdEL on illegal fetch addresses. It sits between the IM and the decode stage of the p7 pipeline, and is driven by the hazard unit and CP0.

---
 rtl/im_fetch_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/im_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the IM address and fills the F/D register.
// Redirect priority is exception > eret > stall > branch > sequential.
module im_fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] IM_BASE    = 32'h0000_3000,
   parameter logic [31:0] IM_LAST    = 32'h0000_6FFC,
   parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] im_addr,
   input  logic [31:0] im_rdata,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic        exc_d,
   output logic [4:0]  exc_code_d,
   output logic        valid_d,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, FLUSH = 2'd2} fst_t;

   fst_t        fst_q, fst_d;
   logic [31:0] pc_q, pc_nxt_d;
   logic [31:0] fd_instr_q, fd_instr_d;
   logic [31:0] fd_pc_q, fd_pc_d;
   logic        fd_exc_q, fd_exc_d;
   logic [4:0]  fd_code_q, fd_code_d;
   logic        fd_valid_q, fd_valid_d;
   logic [31:0] cnt_q, cnt_d;
   logic        illegal;
   logic        redirect;
   logic [31:0] redirect_pc;

   assign illegal     = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LAST);
   assign redirect    = exc_req || eret_req;
   assign redirect_pc = exc_req ? HANDLER_PC : epc;

   // State machine: every state reacts identically to the same input priority.
   always_comb begin
      fst_d = fst_q;
      case (fst_q)
         RUN, HOLD, FLUSH: begin
            if (redirect)   fst_d = FLUSH;
            else if (stall) fst_d = HOLD;
            else            fst_d = RUN;
         end
         default: fst_d = RUN;
      endcase
   end

   always_comb begin
      pc_nxt_d   = pc_q;
      fd_instr_d = fd_instr_q;
      fd_pc_d    = fd_pc_q;
      fd_exc_d   = fd_exc_q;
      fd_code_d  = fd_code_q;
      fd_valid_d = fd_valid_q;
      cnt_d      = cnt_q;
      if (redirect) begin
         // Bubble carries the new target so CP0 always sees a meaningful pc.
         pc_nxt_d   = redirect_pc;
         fd_instr_d = 32'd0;
         fd_pc_d    = redirect_pc;
         fd_exc_d   = 1'b0;
         fd_code_d  = 5'd0;
         fd_valid_d = 1'b0;
      end else if (!stall) begin
         pc_nxt_d   = br_valid ? br_target : pc_q + 32'd4;
         fd_instr_d = illegal ? 32'd0 : im_rdata;
         fd_pc_d    = pc_q;
         fd_exc_d   = illegal;
         fd_code_d  = illegal ? EXC_ADEL : 5'd0;
         fd_valid_d = 1'b1;
         cnt_d      = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fst_q      <= RUN;
         pc_q       <= RESET_PC;
         fd_instr_q <= 32'd0;
         fd_pc_q    <= 32'd0;
         fd_exc_q   <= 1'b0;
         fd_code_q  <= 5'd0;
         fd_valid_q <= 1'b0;
         cnt_q      <= 32'd0;
      end else begin
         fst_q      <= fst_d;
         pc_q       <= pc_nxt_d;
         fd_instr_q <= fd_instr_d;
         fd_pc_q    <= fd_pc_d;
         fd_exc_q   <= fd_exc_d;
         fd_code_q  <= fd_code_d;
         fd_valid_q <= fd_valid_d;
         cnt_q      <= cnt_d;
      end
   end

   assign im_addr    = pc_q;
   assign instr_d    = fd_instr_q;
   assign pc_d       = fd_pc_q;
   assign exc_d      = fd_exc_q;
   assign exc_code_d = fd_code_q;
   assign valid_d    = fd_valid_q;
   assign fetch_cnt  = cnt_q;

endmodule
